// File: rtl/johnson_decoder.sv
`default_nettype none
// ============================================================================
// Module      : johnson_decoder
// Description : Receive-side Johnson code checker/decoder. Each sampled code
//               is checked for legality and converted to a binary index.
//               Successive codes must advance by +1 (mod 2N). After LOCK_LEN
//               correctly stepping codes the decoder locks. Illegal codes and
//               wrong steps while locked are flagged and counted in a
//               saturating error counter.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-high reset
//               code_in    - N-bit Johnson code sample
//               code_valid - code_in is sampled on this edge
//               idx_out    - binary index of last legal code
//               idx_valid  - pulse: idx_out updated while locked
//               locked     - decoder is in LOCKED state
//               illegal    - pulse: sampled code is not a legal Johnson code
//               step_err   - pulse: legal code, wrong successor while locked
//               err_count  - saturating count of illegal + step_err events
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_decoder #(
    parameter int N        = 4,
    parameter int LOCK_LEN = 3,
    parameter int ERRCNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              code_in,
    input  logic                      code_valid,
    output logic [$clog2(2*N)-1:0]    idx_out,
    output logic                      idx_valid,
    output logic                      locked,
    output logic                      illegal,
    output logic                      step_err,
    output logic [ERRCNT_W-1:0]       err_count
);

    localparam int M  = 2 * N;
    localparam int IW = $clog2(M);
    localparam int SW = $clog2(LOCK_LEN + 1);

    localparam logic [1:0] S_UNLOCKED = 2'd0;
    localparam logic [1:0] S_ACQUIRE  = 2'd1;
    localparam logic [1:0] S_LOCKED   = 2'd2;

    // ------------------------------------------------------------------
    // Code classification
    // ------------------------------------------------------------------
    logic [N-2:0] adj_diff;
    logic         code_legal;
    logic [IW-1:0] ones;
    logic [IW-1:0] code_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_adj_diff
            assign adj_diff[gi] = code_in[gi] ^ code_in[gi+1];
        end
    endgenerate

    // Legal iff at most one adjacent pair differs (zero or one bit set).
    assign code_legal = ((adj_diff & (adj_diff - 1'b1)) == '0);

    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + IW'(code_in[i]);
        end
    end

    // Upper half of the ring (MSB=1) counts ones directly; the lower half
    // counts down from 2N as the ones shift out of the LSB side.
    always_comb begin
        if (code_in[N-1]) begin
            code_idx = ones;
        end else if (ones == '0) begin
            code_idx = '0;
        end else begin
            code_idx = IW'(M) - ones;
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          state_q,     state_d;
    logic [SW-1:0]       streak_q,    streak_d;
    logic [IW-1:0]       prev_q,      prev_d;
    logic [IW-1:0]       idx_q,       idx_d;
    logic                idx_valid_q, idx_valid_d;
    logic                illegal_q,   illegal_d;
    logic                step_err_q,  step_err_d;
    logic [ERRCNT_W-1:0] err_q,       err_d;

    logic [IW-1:0] succ_idx;
    logic          is_succ;
    logic          is_stall;

    // Explicit wrap keeps the successor correct when 2N is not a power of 2.
    assign succ_idx = (prev_q == IW'(M - 1)) ? '0 : prev_q + 1'b1;
    assign is_succ  = (code_idx == succ_idx);
    assign is_stall = (code_idx == prev_q);

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        prev_d      = prev_q;
        idx_d       = idx_q;
        idx_valid_d = 1'b0;
        illegal_d   = 1'b0;
        step_err_d  = 1'b0;
        err_d       = err_q;

        if (code_valid) begin
            if (!code_legal) begin
                // idx_out and prev index hold their last legal values.
                illegal_d = 1'b1;
                state_d   = S_UNLOCKED;
                streak_d  = '0;
            end else begin
                idx_d  = code_idx;
                prev_d = code_idx;
                case (state_q)
                    S_ACQUIRE: begin
                        if (is_succ) begin
                            streak_d = streak_q + 1'b1;
                            if (streak_q == SW'(LOCK_LEN - 1)) begin
                                state_d     = S_LOCKED;
                                idx_valid_d = 1'b1;
                            end
                        end else begin
                            // Restart acquisition from this code, silently.
                            streak_d = SW'(1);
                        end
                    end
                    S_LOCKED: begin
                        if (is_succ || is_stall) begin
                            idx_valid_d = 1'b1;
                        end else begin
                            step_err_d = 1'b1;
                            state_d    = S_ACQUIRE;
                            streak_d   = SW'(1);
                        end
                    end
                    default: begin
                        state_d  = S_ACQUIRE;
                        streak_d = SW'(1);
                    end
                endcase
            end

            if ((illegal_d || step_err_d) && (err_q != '1)) begin
                err_d = err_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_UNLOCKED;
            streak_q    <= '0;
            prev_q      <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            step_err_q  <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            prev_q      <= prev_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            illegal_q   <= illegal_d;
            step_err_q  <= step_err_d;
            err_q       <= err_d;
        end
    end

    assign idx_out   = idx_q;
    assign idx_valid = idx_valid_q;
    assign locked    = (state_q == S_LOCKED);
    assign illegal   = illegal_q;
    assign step_err  = step_err_q;
    assign err_count = err_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_johnson_decoder
// Description : Directed self-checking bench for johnson_decoder. A second
//               instance with a 2-bit error counter shares the stimulus to
//               exercise counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] code_in;
    logic       code_valid;

    logic [2:0] idx_out;
    logic       idx_valid;
    logic       locked;
    logic       illegal;
    logic       step_err;
    logic [7:0] err_count;

    logic [2:0] s_idx_out;
    logic       s_idx_valid;
    logic       s_locked;
    logic       s_illegal;
    logic       s_step_err;
    logic [1:0] s_err_count;

    int checks = 0;
    int errors = 0;

    johnson_decoder #(.N(4), .LOCK_LEN(3), .ERRCNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .idx_out    (idx_out),
        .idx_valid  (idx_valid),
        .locked     (locked),
        .illegal    (illegal),
        .step_err   (step_err),
        .err_count  (err_count)
    );

    johnson_decoder #(.N(4), .LOCK_LEN(3), .ERRCNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .idx_out    (s_idx_out),
        .idx_valid  (s_idx_valid),
        .locked     (s_locked),
        .illegal    (s_illegal),
        .step_err   (s_step_err),
        .err_count  (s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one sample away from the edge, then settle just after the edge.
    task automatic feed(input logic [3:0] c, input logic v);
        @(negedge clk);
        code_in    = c;
        code_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input int idx, input int iv,
                              input int lk, input int il, input int se, input int ec);
        check({tag, ".idx"},      32'(idx_out),   idx);
        check({tag, ".idx_valid"},32'(idx_valid), iv);
        check({tag, ".locked"},   32'(locked),    lk);
        check({tag, ".illegal"},  32'(illegal),   il);
        check({tag, ".step_err"}, 32'(step_err),  se);
        check({tag, ".err_count"},32'(err_count), ec);
    endtask

    initial begin
        rst        = 1'b1;
        code_in    = 4'b0000;
        code_valid = 1'b0;
        #12;
        expect_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Clean ring: locks on the third correctly stepping code.
        feed(4'b0000, 1'b1); expect_all("ring0", 0, 0, 0, 0, 0, 0);
        feed(4'b1000, 1'b1); expect_all("ring1", 1, 0, 0, 0, 0, 0);
        feed(4'b1100, 1'b1); expect_all("ring2", 2, 1, 1, 0, 0, 0);
        feed(4'b1110, 1'b1); expect_all("ring3", 3, 1, 1, 0, 0, 0);

        // Wrap-around 7 -> 0 while locked.
        feed(4'b1111, 1'b1); expect_all("ring4", 4, 1, 1, 0, 0, 0);
        feed(4'b0111, 1'b1); expect_all("ring5", 5, 1, 1, 0, 0, 0);
        feed(4'b0011, 1'b1); expect_all("wrap6", 6, 1, 1, 0, 0, 0);
        feed(4'b0001, 1'b1); expect_all("wrap7", 7, 1, 1, 0, 0, 0);
        feed(4'b0000, 1'b1); expect_all("wrap0", 0, 1, 1, 0, 0, 0);
        feed(4'b1000, 1'b1); expect_all("wrap1", 1, 1, 1, 0, 0, 0);

        // Illegal code while locked at idx 3.
        feed(4'b1100, 1'b1); expect_all("pre_il2", 2, 1, 1, 0, 0, 0);
        feed(4'b1110, 1'b1); expect_all("pre_il3", 3, 1, 1, 0, 0, 0);
        feed(4'b1010, 1'b1); expect_all("illegal", 3, 0, 0, 1, 0, 1);
        feed(4'b1111, 1'b1); expect_all("reacq4",  4, 0, 0, 0, 0, 1);
        feed(4'b0111, 1'b1); expect_all("reacq5",  5, 0, 0, 0, 0, 1);
        feed(4'b0011, 1'b1); expect_all("relock6", 6, 1, 1, 0, 0, 1);

        // Skipped step while locked at idx 2.
        feed(4'b0001, 1'b1); expect_all("pre_sk7", 7, 1, 1, 0, 0, 1);
        feed(4'b0000, 1'b1); expect_all("pre_sk0", 0, 1, 1, 0, 0, 1);
        feed(4'b1000, 1'b1); expect_all("pre_sk1", 1, 1, 1, 0, 0, 1);
        feed(4'b1100, 1'b1); expect_all("pre_sk2", 2, 1, 1, 0, 0, 1);
        feed(4'b1111, 1'b1); expect_all("skip",    4, 0, 0, 0, 1, 2);
        feed(4'b0111, 1'b1); expect_all("sk_acq5", 5, 0, 0, 0, 0, 2);
        feed(4'b0011, 1'b1); expect_all("sk_lock", 6, 1, 1, 0, 0, 2);

        // Stall (repeat of current code) is accepted while locked.
        feed(4'b0011, 1'b1); expect_all("stall", 6, 1, 1, 0, 0, 2);

        // Gaps: an illegal pattern on code_in is ignored without code_valid.
        for (int i = 0; i < 4; i++) begin
            feed(4'b1010, 1'b0);
            expect_all($sformatf("gap%0d", i), 6, 0, 1, 0, 0, 2);
        end
        feed(4'b0001, 1'b1); expect_all("post_gap", 7, 1, 1, 0, 0, 2);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_all("async_rst", 0, 0, 0, 0, 0, 0);
        check("async_rst.sat_err", 32'(s_err_count), 0);
        @(negedge clk);
        rst = 1'b0;

        // Legal non-successor in ACQUIRE restarts the streak silently.
        feed(4'b0000, 1'b1); expect_all("acq0",   0, 0, 0, 0, 0, 0);
        feed(4'b1100, 1'b1); expect_all("acq_ns", 2, 0, 0, 0, 0, 0);
        feed(4'b1110, 1'b1); expect_all("acq3",   3, 0, 0, 0, 0, 0);
        feed(4'b1111, 1'b1); expect_all("acq4",   4, 1, 1, 0, 0, 0);

        // Five illegal codes: 8-bit counter reaches 5, 2-bit saturates at 3.
        feed(4'b1010, 1'b1); expect_all("sat1", 4, 0, 0, 1, 0, 1);
        feed(4'b0101, 1'b1); expect_all("sat2", 4, 0, 0, 1, 0, 2);
        feed(4'b1001, 1'b1); expect_all("sat3", 4, 0, 0, 1, 0, 3);
        check("sat3.sat_err", 32'(s_err_count), 3);
        feed(4'b0110, 1'b1); expect_all("sat4", 4, 0, 0, 1, 0, 4);
        feed(4'b1011, 1'b1); expect_all("sat5", 4, 0, 0, 1, 0, 5);
        check("sat5.sat_err",     32'(s_err_count), 3);
        check("sat5.sat_illegal", 32'(s_illegal),   1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
